// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: opcode constants, burst FSM
// state encoding and a core memory-op decode helper.
package dmem_arb_pkg;

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBURST = 2'd1,
        RBURST = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    // True when the executing instruction touches data memory this cycle.
    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-RAM port between the single-cycle core
// (always wins, zero wait states) and a burst DMA requester whose word beats
// use only cycles in which the core is not executing a LOAD or STORE.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   core_*                     core data port (instr opcode decode, addr, wdata,
//                              strobe, write enable, load data back)
//   mem_*                      RAM port (combinational read, synchronous write)
//   dma_cmd_*                  burst command (we, word-aligned addr, len = beats-1)
//   dma_wdata_*                write-beat stream
//   dma_rdata_valid/dma_rdata  read-beat stream, one cycle after the beat
//   dma_done                   one-cycle pulse after the last beat
//   dma_starve_cnt             count of DMA beats blocked by core accesses
//
// Build option
//   DMEM_ARB_STARVE_CNT_EN  when defined, dma_starve_cnt is a saturating count
//                           of blocked-but-ready beats; otherwise tied to 0.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       core_instr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [3:0]        core_strobe,
    input  logic              core_mem_write,
    output logic [31:0]       core_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_strobe,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    input  logic              dma_cmd_valid,
    output logic              dma_cmd_ready,
    input  logic              dma_cmd_we,
    input  logic [ADDR_W-1:0] dma_cmd_addr,
    input  logic [LEN_W-1:0]  dma_cmd_len,
    input  logic              dma_wdata_valid,
    output logic              dma_wdata_ready,
    input  logic [31:0]       dma_wdata,
    output logic              dma_rdata_valid,
    output logic [31:0]       dma_rdata,
    output logic              dma_done,
    output logic [15:0]       dma_starve_cnt
);

    arb_state_t        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [31:0]       rdata_q;
    logic              rvalid_q;

    logic core_acc;
    logic wr_fire;
    logic rd_fire;
    logic cmd_accept;

    // Opcode bits above [6:0] and the command's byte offset are don't-care.
    logic unused_bits;
    assign unused_bits = ^{core_instr[31:7], dma_cmd_addr[1:0]};

    assign core_acc   = is_mem_op(core_instr[6:0]);
    assign wr_fire    = (state_q == WBURST) && dma_wdata_valid && !core_acc;
    assign rd_fire    = (state_q == RBURST) && !core_acc;
    assign cmd_accept = (state_q == IDLE) && dma_cmd_valid;

    assign core_rdata      = mem_rdata;
    assign dma_cmd_ready   = (state_q == IDLE);
    assign dma_done        = (state_q == DONE);
    assign dma_rdata_valid = rvalid_q;
    assign dma_rdata       = rdata_q;

    // RAM port mux: core has absolute priority; DMA drives only on a fired beat.
    always_comb begin
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_strobe      = 4'h0;
        mem_we          = 1'b0;
        dma_wdata_ready = 1'b0;
        if (core_acc) begin
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
            mem_strobe = core_strobe;
            mem_we     = core_mem_write;
        end else begin
            if (state_q != IDLE) begin
                mem_addr = addr_q;
            end
            if (wr_fire) begin
                mem_we          = 1'b1;
                mem_strobe      = 4'hF;
                mem_wdata       = dma_wdata;
                dma_wdata_ready = 1'b1;
            end
        end
    end

    // Burst FSM with address/count tracking and registered read-beat return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_accept) begin
                        addr_q  <= {dma_cmd_addr[ADDR_W-1:2], 2'b00};
                        cnt_q   <= dma_cmd_len;
                        state_q <= dma_cmd_we ? WBURST : RBURST;
                    end
                end
                WBURST, RBURST: begin
                    if (wr_fire || rd_fire) begin
                        addr_q <= addr_q + ADDR_W'(WORD_BYTES);
                        if (rd_fire) begin
                            rdata_q  <= mem_rdata;
                            rvalid_q <= 1'b1;
                        end
                        if (cnt_q == '0) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q - LEN_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STARVE_CNT_EN
    logic [15:0] starve_q;
    logic [15:0] starve_d;
    logic        beat_blocked;

    // A beat is blocked when it would have fired but the core owns the port.
    assign beat_blocked = core_acc &&
                          ((state_q == RBURST) || ((state_q == WBURST) && dma_wdata_valid));

    always_comb begin
        starve_d = starve_q;
        if (cmd_accept) begin
            starve_d = '0;
        end else if (beat_blocked && (starve_q != 16'hFFFF)) begin
            starve_d = starve_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign dma_starve_cnt = starve_q;
`else
    assign dma_starve_cnt = 16'h0000;
`endif

endmodule
